// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Recovers command frames from the byte stream of a UART receiver:
//     [SYNC][CMD][LEN][PAYLOAD x LEN][CSUM]
// The checksum is the XOR of CMD, LEN and every payload byte; SYNC and CSUM are
// not included. A good frame is held on cmd_* with cmd_valid high until the
// consumer takes it with cmd_ready. Checksum, length, overrun and (optionally)
// timeout errors are reported as single-cycle pulses.
//
// Optional feature: define CMD_TIMEOUT_EN to enable the inter-byte timeout.
// A partial frame is then abandoned after TIMEOUT_CYCLES clocks without a byte.
// When undefined, err_timeout is tied low and a partial frame waits forever.
//
// Parameters:
//   MAX_LEN         maximum payload bytes per frame (1..16)
//   SYNC_BYTE       frame start marker
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (CMD_TIMEOUT_EN only)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx_data      in   received byte
//   rx_valid     in   one-cycle strobe, rx_data valid
//   cmd_code     out  command byte of held frame (0 when nothing held)
//   cmd_len      out  payload length of held frame
//   cmd_payload  out  payload, byte i at [8*i+7:8*i], unused bytes 0
//   cmd_valid    out  frame held and available
//   cmd_ready    in   consumer accepts the frame when cmd_valid & cmd_ready
//   err_csum     out  pulse: checksum mismatch
//   err_len      out  pulse: LEN > MAX_LEN
//   err_overrun  out  pulse: byte arrived while a frame was held (byte dropped)
//   err_timeout  out  pulse: inter-byte timeout
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter int          MAX_LEN        = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int          TIMEOUT_CYCLES = 1250000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             cmd_code,
    output logic [4:0]             cmd_len,
    output logic [MAX_LEN*8-1:0]   cmd_payload,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   err_csum,
    output logic                   err_len,
    output logic                   err_overrun,
    output logic                   err_timeout
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        code_q, code_d;
    logic [4:0]        len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              err_csum_q, err_csum_d;
    logic              err_len_q, err_len_d;
    logic              err_ovr_q, err_ovr_d;
    logic              buf_we;
    logic              buf_clr;
    logic              timeout_hit;
    logic              last_byte;
    logic              len_too_big;

    // Current payload byte is the final one of the frame.
    assign last_byte   = ((5'(idx_q) + 5'd1) == len_q);
    assign len_too_big = (rx_data > 8'(MAX_LEN));

    // ------------------------------------------------------------------ state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = ST_HUNT;
        end else begin
            case (state_q)
                ST_HUNT:    if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_CMD;
                ST_CMD:     if (rx_valid) state_d = ST_LEN;
                ST_LEN: begin
                    if (rx_valid) begin
                        if (len_too_big)          state_d = ST_HUNT;
                        else if (rx_data == 8'd0) state_d = ST_CSUM;
                        else                      state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (rx_valid && last_byte) state_d = ST_CSUM;
                ST_CSUM: begin
                    if (rx_valid) state_d = (rx_data == csum_q) ? ST_HOLD : ST_HUNT;
                end
                // A byte arriving together with cmd_ready is still dropped.
                ST_HOLD:    if (cmd_ready) state_d = ST_HUNT;
                default:    state_d = ST_HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------ outputs / datapath control
    always_comb begin
        code_d     = code_q;
        len_d      = len_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        buf_we     = 1'b0;
        buf_clr    = 1'b0;
        err_csum_d = 1'b0;
        err_len_d  = 1'b0;
        err_ovr_d  = 1'b0;
        if (timeout_hit) begin
            buf_clr = 1'b1;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    // Clear at frame start so unused payload bytes always read 0.
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        buf_clr = 1'b1;
                        code_d  = 8'd0;
                        len_d   = 5'd0;
                        idx_d   = '0;
                        csum_d  = 8'd0;
                    end
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        code_d = rx_data;
                        csum_d = rx_data;
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        if (len_too_big) begin
                            err_len_d = 1'b1;
                        end else begin
                            len_d  = rx_data[4:0];
                            csum_d = csum_q ^ rx_data;
                            idx_d  = '0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        buf_we = 1'b1;
                        csum_d = csum_q ^ rx_data;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
                ST_CSUM: begin
                    if (rx_valid && rx_data != csum_q) err_csum_d = 1'b1;
                end
                ST_HOLD: begin
                    if (rx_valid)  err_ovr_d = 1'b1;
                    if (cmd_ready) buf_clr   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q     <= 8'd0;
            len_q      <= 5'd0;
            idx_q      <= '0;
            csum_q     <= 8'd0;
            err_csum_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            code_q     <= code_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            err_csum_q <= err_csum_d;
            err_len_q  <= err_len_d;
            err_ovr_q  <= err_ovr_d;
        end
    end

    assign cmd_valid   = (state_q == ST_HOLD);
    assign cmd_code    = cmd_valid ? code_q : 8'd0;
    assign cmd_len     = cmd_valid ? len_q  : 5'd0;
    assign err_csum    = err_csum_q;
    assign err_len     = err_len_q;
    assign err_overrun = err_ovr_q;

    // ------------------------------------------------------------------ payload buffer
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : gen_buf
            logic [7:0] byte_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byte_q <= 8'd0;
                end else if (buf_clr) begin
                    byte_q <= 8'd0;
                end else if (buf_we && idx_q == IDX_W'(gi)) begin
                    byte_q <= rx_data;
                end
            end
            assign cmd_payload[8*gi +: 8] = cmd_valid ? byte_q : 8'd0;
        end
    endgenerate

    // ------------------------------------------------------------------ inter-byte timeout
`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_timeout_q;
    logic             in_frame;

    // HUNT and HOLD never time out.
    assign in_frame    = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                         (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
    assign timeout_hit = in_frame && !rx_valid &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= timeout_hit;
            if (rx_valid || !in_frame || timeout_hit) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
        end
    end

    assign err_timeout = err_timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Drives directed and randomized command frames into uart_cmd_parser. Each
// frame is described by its fields (code, length, payload, checksum corruption)
// and the expected outcome follows directly from those fields: good frames are
// held, a corrupted checksum gives one err_csum pulse, an oversize LEN gives one
// err_len pulse. Error pulses are counted by a monitor and compared against the
// expected totals; held frames are checked field by field, through overrun
// bytes and release.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int         MAX_LEN = 8;
    localparam logic [7:0] SYNC    = 8'hAA;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           rx_data = 8'd0;
    logic                 rx_valid = 1'b0;
    logic                 cmd_ready = 1'b0;
    logic [7:0]           cmd_code;
    logic [4:0]           cmd_len;
    logic [MAX_LEN*8-1:0] cmd_payload;
    logic                 cmd_valid;
    logic                 err_csum;
    logic                 err_len;
    logic                 err_overrun;
    logic                 err_timeout;

    uart_cmd_parser #(
        .MAX_LEN       (MAX_LEN),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_code   (cmd_code),
        .cmd_len    (cmd_len),
        .cmd_payload(cmd_payload),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .err_csum   (err_csum),
        .err_len    (err_len),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters (one count per cycle high) and expected totals.
    int mon_csum = 0, mon_len = 0, mon_ovr = 0, mon_tmo = 0;
    int exp_csum = 0, exp_len = 0, exp_ovr = 0;
    int frame_no = 0;

    // Reference for the currently held frame.
    logic [7:0]  held_code;
    int          held_len;
    logic [63:0] held_pl;

    // Payload source for the next frame.
    logic [63:0] pl_g;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_csum += int'(err_csum);
            mon_len  += int'(err_len);
            mon_ovr  += int'(err_overrun);
            mon_tmo  += int'(err_timeout);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the monitor to sample the latest edge, then compare pulse totals.
    task automatic check_counts();
        @(negedge clk);
        #1;
        check_eq("n_err_csum", 64'(mon_csum), 64'(exp_csum));
        check_eq("n_err_len", 64'(mon_len), 64'(exp_len));
        check_eq("n_err_overrun", 64'(mon_ovr), 64'(exp_ovr));
        check_eq("n_err_timeout", 64'(mon_tmo), 64'd0);
    endtask

    // One byte strobe after 0..2 idle cycles; returns 1 time unit after the edge.
    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Send a frame; flip != 0 corrupts the checksum, len > MAX_LEN is oversize.
    task automatic frame(input logic [7:0] code, input int len, input logic [7:0] flip,
                         input int npre);
        logic [63:0] exp_pl;
        logic [7:0]  cs;
        logic [7:0]  b;
        exp_pl = '0;
        frame_no++;
        for (int i = 0; i < npre; i++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h55;
            send_byte(b);
        end
        send_byte(SYNC);
        send_byte(code);
        send_byte(8'(len));
        cs = code ^ 8'(len);
        if (len > MAX_LEN) begin
            exp_len++;
            check_eq("lenerr_valid", 64'(cmd_valid), 64'd0);
            check_counts();
            $display("frame %0d: code=%02h len=%0d -> length error", frame_no, code, len);
            return;
        end
        for (int i = 0; i < len; i++) begin
            b = pl_g[8*i +: 8];
            exp_pl[8*i +: 8] = b;
            cs = cs ^ b;
            send_byte(b);
        end
        send_byte(cs ^ flip);
        if (flip != 8'd0) begin
            exp_csum++;
            check_eq("csumerr_valid", 64'(cmd_valid), 64'd0);
            check_counts();
            $display("frame %0d: code=%02h len=%0d -> checksum error", frame_no, code, len);
        end else begin
            held_code = code;
            held_len  = len;
            held_pl   = exp_pl;
            check_eq("valid", 64'(cmd_valid), 64'd1);
            check_eq("code", 64'(cmd_code), 64'(code));
            check_eq("len", 64'(cmd_len), 64'(len));
            check_eq("payload", 64'(cmd_payload), exp_pl);
            check_counts();
            $display("frame %0d: code=%02h len=%0d payload=%016h -> held", frame_no, code, len,
                     exp_pl);
        end
    endtask

    // Drop n bytes into the held frame, then release it (optionally with a byte).
    task automatic release_frame(input int n_ovr, input bit with_byte);
        for (int i = 0; i < n_ovr; i++) begin
            send_byte(8'($urandom));
            exp_ovr++;
            check_eq("ovr_valid", 64'(cmd_valid), 64'd1);
            check_eq("ovr_code", 64'(cmd_code), 64'(held_code));
            check_eq("ovr_len", 64'(cmd_len), 64'(held_len));
            check_eq("ovr_payload", 64'(cmd_payload), held_pl);
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("hold_valid", 64'(cmd_valid), 64'd1);
        cmd_ready = 1'b1;
        if (with_byte) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            exp_ovr++;
        end
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        rx_valid  = 1'b0;
        check_eq("rel_valid", 64'(cmd_valid), 64'd0);
        check_eq("rel_code", 64'(cmd_code), 64'd0);
        check_eq("rel_len", 64'(cmd_len), 64'd0);
        check_eq("rel_payload", 64'(cmd_payload), 64'd0);
        check_counts();
        $display("release: %0d overrun bytes, byte with ready=%0d", n_ovr, with_byte);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 64'(cmd_valid), 64'd0);
        check_eq({tag, "_code"}, 64'(cmd_code), 64'd0);
        check_eq({tag, "_len"}, 64'(cmd_len), 64'd0);
        check_eq({tag, "_payload"}, 64'(cmd_payload), 64'd0);
        check_eq({tag, "_errs"}, 64'({err_csum, err_len, err_overrun, err_timeout}), 64'd0);
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int kind;
        int len;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int len;
        logic [7:0] flip;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        leave_reset();

        // Basic two-byte frame, held until ready
        pl_g = 64'h2010;
        frame(8'h01, 2, 8'h00, 0);
        release_frame(0, 1'b0);

        // Zero-length frame, then with a leading junk byte
        pl_g = 64'h0;
        frame(8'h05, 0, 8'h00, 0);
        release_frame(0, 1'b0);
        frame(8'h05, 0, 8'h00, 1);
        release_frame(0, 1'b0);

        // Checksum error followed by a good frame
        pl_g = 64'h2010;
        frame(8'h01, 2, 8'h07, 0);
        frame(8'h01, 2, 8'h00, 0);
        release_frame(0, 1'b0);

        // Oversize LEN, then a frame whose payload byte is the sync value
        frame(8'h01, MAX_LEN + 1, 8'h00, 0);
        pl_g = 64'hAA;
        frame(8'h02, 1, 8'h00, 0);
        release_frame(0, 1'b0);

        // Maximum-length frame, overruns while held, byte coincident with ready
        pl_g = 64'hAA12_3456_789A_BCDE;
        frame(8'h3C, MAX_LEN, 8'h00, 0);
        release_frame(3, 1'b0);
        pl_g = 64'h0000_0000_00C0_FFEE;
        frame(8'h7E, 3, 8'h00, 0);
        release_frame(1, 1'b1);

        // Reset mid-frame discards the partial frame
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h10);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        leave_reset();
        pl_g = 64'h2010;
        frame(8'h01, 2, 8'h00, 0);
        release_frame(0, 1'b0);

        // Reset while holding clears outputs immediately
        pl_g = 64'h0000_0000_0000_5A5A;
        frame(8'h11, 2, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_hold");
        leave_reset();

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            pl_g = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) pl_g[7:0] = SYNC;
            if (kind < 6) begin
                len = $urandom_range(0, MAX_LEN);
                frame(8'($urandom), len, 8'h00, $urandom_range(0, 2));
                release_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else if (kind < 8) begin
                len  = $urandom_range(0, MAX_LEN);
                flip = 8'($urandom_range(1, 255));
                frame(8'($urandom), len, flip, $urandom_range(0, 2));
            end else begin
                len = $urandom_range(MAX_LEN + 1, 255);
                frame(8'($urandom), len, 8'h00, $urandom_range(0, 2));
            end
        end

        repeat (5) @(posedge clk);
        check_counts();
        check_eq("final_valid", 64'(cmd_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
